// File: rtl/keccak_byte_packer.sv
// rtl/keccak_byte_packer.sv - packs a byte stream big-endian into 32-bit words for the keccak core
// Emits the core's end-of-message encoding: partial last word or an extra zero terminator word.
module keccak_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_void,
  output logic        s_ready,
  output logic [31:0] k_in,
  output logic        k_in_ready,
  output logic        k_is_last,
  output logic [1:0]  k_byte_num,
  input  logic        k_buffer_full,
  output logic        done
);

  typedef enum logic {FILL, TERM} state_t;

  state_t      state, state_next;
  logic [23:0] acc;
  logic [1:0]  cnt;
  logic        slot_free;
  logic        load, load_last, append;
  logic [31:0] load_word;
  logic [1:0]  load_num;

  // Left-justify the n right-aligned bytes of d, zero-filling the low bytes.
  function automatic logic [31:0] pack(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    pack = 32'h0;
      3'd1:    pack = {d[7:0], 24'h0};
      3'd2:    pack = {d[15:0], 16'h0};
      3'd3:    pack = {d[23:0], 8'h0};
      default: pack = d;
    endcase
  endfunction

  assign slot_free = ~k_in_ready | ~k_buffer_full;

  always_ff @(posedge clk) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    load       = 1'b0;
    load_word  = 32'h0;
    load_last  = 1'b0;
    load_num   = 2'd0;
    append     = 1'b0;
    case (state)
      FILL: begin
        // Bytes that only land in acc may proceed even while the slot is stalled.
        s_ready = (slot_free | ((cnt != 2'd3) & ~(s_last | s_void))) & reset;
        if (s_valid & s_ready) begin
          if (s_void & s_last) begin
            load      = 1'b1;
            load_word = pack({8'h00, acc}, {1'b0, cnt});
            load_last = 1'b1;
            load_num  = cnt;
          end else if (cnt != 2'd3) begin
            if (s_last) begin
              load      = 1'b1;
              load_word = pack({acc, s_byte}, {1'b0, cnt} + 3'd1);
              load_last = 1'b1;
              load_num  = cnt + 2'd1;
            end else begin
              append = 1'b1;
            end
          end else begin
            load      = 1'b1;
            load_word = {acc, s_byte};
            if (s_last) state_next = TERM;
          end
        end
      end
      TERM: begin
        if (slot_free) begin
          load       = 1'b1;
          load_last  = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc        <= 24'h0;
      cnt        <= 2'd0;
      k_in       <= 32'h0;
      k_in_ready <= 1'b0;
      k_is_last  <= 1'b0;
      k_byte_num <= 2'd0;
      done       <= 1'b0;
    end else begin
      done <= k_in_ready & ~k_buffer_full & k_is_last;
      if (load) begin
        k_in       <= load_word;
        k_is_last  <= load_last;
        k_byte_num <= load_num;
        k_in_ready <= 1'b1;
        acc        <= 24'h0;
        cnt        <= 2'd0;
      end else begin
        if (k_in_ready & ~k_buffer_full) k_in_ready <= 1'b0;
        if (append) begin
          acc <= {acc[15:0], s_byte};
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule
